// File: rtl/apb_spi_fifo_regif.sv
// APB3 slave register block for the SPI core: CR1/CR2/BR/SR/DR with TX and RX FIFOs.
// Latency: writes commit and DR pops occur on the edge ending ENABLE; PRDATA loads on SETUP->ENABLE.
// Backpressure: DR write to a full TX FIFO is dropped with PSLVERR; RX push to a full FIFO sets sticky RXOVR.
// Ports: APB3 slave (PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR);
//        shifter side (ss, tip, receive_data, miso_data, send_data, mosi_data); control fields
//        (mstr, cpol, cpha, lsbfe, spiswai, sppr, spr, spi_mode); spi_interrupt_request.
// Optional feature: define SPI_FIFO_THRESH_EN to map the RX threshold register THR at address 4.
module apb_spi_fifo_regif #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [2:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              ss,
  input  logic              tip,
  input  logic              receive_data,
  input  logic [DATA_W-1:0] miso_data,
  output logic              send_data,
  output logic [DATA_W-1:0] mosi_data,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic [1:0]        spi_mode,
  output logic              spi_interrupt_request
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ENABLE} apb_state_t;

  apb_state_t state_q, state_d;

  logic [7:0]  cr1_q, cr2_q, br_q;
  logic        rxovr_q;
  logic        rx_rd_ok_q;
`ifdef SPI_FIFO_THRESH_EN
  logic [AW:0] thr_q;
  logic [AW:0] thr_eff;
`endif

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0]     tx_cnt, rx_cnt;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic spie, spe, sptie;
  logic access, dr_sel, addr_mapped, reg_wr;
  logic tx_pop, tx_push_req, tx_drop, tx_push;
  logic rx_pop, rx_drop, rx_push, rx_term;
  logic [7:0]        sr_val;
  logic [DATA_W-1:0] rdata;

  assign spie    = cr1_q[7];
  assign spe     = cr1_q[6];
  assign sptie   = cr1_q[5];
  assign mstr    = cr1_q[4];
  assign cpol    = cr1_q[3];
  assign cpha    = cr1_q[2];
  assign lsbfe   = cr1_q[0];
  assign spiswai = cr2_q[1];
  assign sppr    = br_q[6:4];
  assign spr     = br_q[2:0];

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);

  assign sr_val = {~rx_empty, 1'b0, ~tx_full, tx_empty, rx_full, 2'b00, rxovr_q};

  // APB state machine
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (PSEL && !PENABLE) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ENABLE;
      ST_ENABLE: state_d = (PSEL && !PENABLE) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign access = (state_q == ST_ENABLE);
  assign PREADY = access;
  assign dr_sel = (PADDR == 3'd5);

  always_comb begin
    addr_mapped = 1'b0;
    case (PADDR)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd5: addr_mapped = 1'b1;
`ifdef SPI_FIFO_THRESH_EN
      3'd4: addr_mapped = 1'b1;
`endif
      default: addr_mapped = 1'b0;
    endcase
  end

  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // only dropped when the shifter is not taking a word at that edge.
  assign tx_pop      = spe & ~tip & ~tx_empty & ~send_data & (mstr | ss);
  assign tx_push_req = access & PWRITE & dr_sel;
  assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
  assign tx_push     = tx_push_req & ~tx_drop;
  assign PSLVERR     = access & (~addr_mapped | tx_drop);
  assign reg_wr      = access & PWRITE & addr_mapped & ~tx_drop;

  // The pop decision follows what PRDATA captured in SETUP, so a word that
  // lands between SETUP and ENABLE is never consumed without being returned.
  assign rx_pop  = access & ~PWRITE & dr_sel & rx_rd_ok_q;
  assign rx_drop = receive_data & rx_full & ~rx_pop;
  assign rx_push = receive_data & ~rx_drop;

`ifdef SPI_FIFO_THRESH_EN
  assign thr_eff = (thr_q == '0) ? CW'(1) : thr_q;
  assign rx_term = (rx_cnt >= thr_eff) | rxovr_q;
`else
  assign rx_term = ~rx_empty | rxovr_q;
`endif

  always_comb begin
    rdata = '0;
    case (PADDR)
      3'd0: rdata = DATA_W'(cr1_q);
      3'd1: rdata = DATA_W'(cr2_q);
      3'd2: rdata = DATA_W'(br_q);
      3'd3: rdata = DATA_W'(sr_val);
`ifdef SPI_FIFO_THRESH_EN
      3'd4: rdata = DATA_W'(thr_q);
`endif
      3'd5: if (!rx_empty) rdata = rx_mem[rx_rptr];
      default: rdata = '0;
    endcase
  end

  // FIFO storage carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wptr] <= PWDATA;
    if (rx_push) rx_mem[rx_wptr] <= miso_data;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA                <= '0;
      rx_rd_ok_q            <= 1'b0;
      cr1_q                 <= 8'h04;
      cr2_q                 <= 8'h00;
      br_q                  <= 8'h00;
`ifdef SPI_FIFO_THRESH_EN
      thr_q                 <= CW'(1);
`endif
      rxovr_q               <= 1'b0;
      tx_wptr               <= '0;
      tx_rptr               <= '0;
      tx_cnt                <= '0;
      rx_wptr               <= '0;
      rx_rptr               <= '0;
      rx_cnt                <= '0;
      send_data             <= 1'b0;
      mosi_data             <= '0;
      spi_mode              <= 2'b10;
      spi_interrupt_request <= 1'b0;
    end else begin
      if (state_q == ST_SETUP) begin
        PRDATA     <= addr_mapped ? rdata : '0;
        rx_rd_ok_q <= ~rx_empty;
      end else begin
        PRDATA     <= '0;
      end

      if (reg_wr) begin
        case (PADDR)
          3'd0: cr1_q <= PWDATA[7:0];
          3'd1: cr2_q <= PWDATA[7:0];
          3'd2: br_q  <= PWDATA[7:0] & 8'h77;
`ifdef SPI_FIFO_THRESH_EN
          3'd4: thr_q <= PWDATA[AW:0];
`endif
          default: ;
        endcase
      end

      if (rx_drop)                                    rxovr_q <= 1'b1;
      else if (reg_wr && PADDR == 3'd3 && PWDATA[0])  rxovr_q <= 1'b0;

      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: ;
      endcase

      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: ;
      endcase

      send_data <= tx_pop;
      if (tx_pop) mosi_data <= tx_mem[tx_rptr];

      spi_mode <= !spe ? 2'b10 : (spiswai ? 2'b01 : 2'b00);
      spi_interrupt_request <= (spie & rx_term) | (sptie & tx_empty);
    end
  end

endmodule

// File: tb/tb_apb_spi_fifo_regif.sv
module tb_apb_spi_fifo_regif;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic       ss, tip, receive_data;
  logic [7:0] miso_data, mosi_data;
  logic       send_data, mstr, cpol, cpha, lsbfe, spiswai;
  logic [2:0] sppr, spr;
  logic [1:0] spi_mode;
  logic       spi_interrupt_request;

  apb_spi_fifo_regif #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ss(ss), .tip(tip), .receive_data(receive_data), .miso_data(miso_data),
    .send_data(send_data), .mosi_data(mosi_data), .mstr(mstr), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode),
    .spi_interrupt_request(spi_interrupt_request)
  );

  always #5 PCLK = ~PCLK;

  int passed = 0;
  int total  = 0;
  int pulses = 0;
  int base;

  always @(posedge PCLK) if (send_data === 1'b1) pulses <= pulses + 1;

  // Reference model state (register values and FIFO contents as queues)
  logic [7:0] m_cr1, m_cr2, m_br, m_thr;
  logic       m_ovr;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int         exp_pulses;
  logic [7:0] last_mosi;
  logic       have_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                     input logic inj, input logic [7:0] inj_val,
                     output logic [7:0] rdat, output logic err);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    n = 0;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && n < 8) begin
      @(negedge PCLK);
      n++;
    end
    if (PREADY !== 1'b1) begin
      total++;
      $error("FAIL apb_timeout: observed PREADY %0b expected 1", PREADY);
    end
    rdat = PRDATA;
    err  = PSLVERR;
    if (inj) begin
      receive_data = 1; miso_data = inj_val;
    end
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; receive_data = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic exp_err, input string tag);
    logic [7:0] r; logic e;
    apb(1'b1, a, d, 1'b0, 8'h00, r, e);
    check({tag, "_pslverr"}, e, exp_err);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input logic exp_err, input string tag);
    logic [7:0] r; logic e;
    apb(1'b0, a, 8'h00, 1'b0, 8'h00, r, e);
    check({tag, "_prdata"}, r, exp);
    check({tag, "_pslverr"}, e, exp_err);
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    @(posedge PCLK); #1;
    receive_data = 1; miso_data = v;
    @(posedge PCLK); #1;
    receive_data = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge PCLK);
    @(negedge PCLK);
  endtask

  function automatic logic m_mapped(input logic [2:0] a);
`ifdef SPI_FIFO_THRESH_EN
    return (a <= 3'd5);
`else
    return (a <= 3'd3) || (a == 3'd5);
`endif
  endfunction

  function automatic logic [7:0] m_sr();
    return {rxq.size() != 0, 1'b0, txq.size() < 4, txq.size() == 0, rxq.size() == 4, 2'b00, m_ovr};
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_cr1;
      3'd1: return m_cr2;
      3'd2: return m_br;
      3'd3: return m_sr();
`ifdef SPI_FIFO_THRESH_EN
      3'd4: return m_thr;
`endif
      3'd5: return (rxq.size() != 0) ? rxq[0] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_irq();
    logic rx_term;
`ifdef SPI_FIFO_THRESH_EN
    int t;
    t = (m_thr == 0) ? 1 : int'(m_thr);
    rx_term = (rxq.size() >= t) || m_ovr;
`else
    rx_term = (rxq.size() != 0) || m_ovr;
`endif
    return (m_cr1[7] && rx_term) || (m_cr1[5] && txq.size() == 0);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, d, v;
    logic       e, w, exp_err;
    logic [2:0] a;
    int         op, n;

    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    ss = 0; tip = 0; receive_data = 0; miso_data = 0; PRESETn = 1;

    // Reset state
    #2 PRESETn = 0;
    #1;
    check("rst_prdata", PRDATA, 0);
    check("rst_pready", PREADY, 0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_send", send_data, 0);
    check("rst_mosi", mosi_data, 0);
    check("rst_irq", spi_interrupt_request, 0);
    check("rst_mode", spi_mode, 2'b10);
    check("rst_cpha", cpha, 1);
    check("rst_mstr", mstr, 0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) PRESETn = 1;
    rd(3'd0, 8'h04, 0, "rst_cr1");
    rd(3'd1, 8'h00, 0, "rst_cr2");
    rd(3'd2, 8'h00, 0, "rst_br");
    rd(3'd3, 8'h30, 0, "rst_sr");

    // Single TX word with spe and mstr set
    wr(3'd0, 8'h50, 0, "cr1_run");
    base = pulses;
    wr(3'd5, 8'hA9, 0, "dr_a9");
    settle(6);
    check("tx_one_pulse", pulses - base, 1);
    check("tx_mosi_a9", mosi_data, 8'hA9);
    check("mode_run", spi_mode, 2'b00);
    rd(3'd3, 8'h30, 0, "sr_tx_empty");

    // Fill TX with spe off; fifth write overflows
    wr(3'd0, 8'h10, 0, "cr1_stop");
    base = pulses;
    for (int i = 1; i <= 5; i++) wr(3'd5, 8'(i), (i == 5), "dr_fill");
    rd(3'd3, 8'h00, 0, "sr_tx_full");
    check("tx_no_pop", pulses - base, 0);
    check("mode_stop", spi_mode, 2'b10);

    // Re-enable: four queued words drain, one pulse each
    wr(3'd0, 8'h50, 0, "cr1_drain");
    settle(15);
    check("tx_drain_pulses", pulses - base, 4);
    check("tx_drain_mosi", mosi_data, 8'h04);
    rd(3'd3, 8'h30, 0, "sr_drained");

    // RX overflow and readback
    wr(3'd0, 8'h10, 0, "cr1_rx");
    for (int i = 1; i <= 5; i++) rx_pulse(8'(i * 8'h11));
    rd(3'd3, 8'hB9, 0, "sr_rx_ovr");
    wr(3'd0, 8'h90, 0, "cr1_spie");
    settle(3);
    check("irq_rx", spi_interrupt_request, 1);
    for (int i = 1; i <= 4; i++) rd(3'd5, 8'(i * 8'h11), 0, "dr_rx");
    rd(3'd5, 8'h00, 0, "dr_rx_empty");
    wr(3'd3, 8'h01, 0, "sr_w1c");
    rd(3'd3, 8'h30, 0, "sr_cleared");
    settle(3);
    check("irq_cleared", spi_interrupt_request, 0);
    wr(3'd0, 8'h10, 0, "cr1_back");

    // Unmapped addresses
    wr(3'd6, 8'hFF, 1, "wr_a6");
    wr(3'd7, 8'hFF, 1, "wr_a7");
    rd(3'd6, 8'h00, 1, "rd_a6");
    rd(3'd7, 8'h00, 1, "rd_a7");
`ifndef SPI_FIFO_THRESH_EN
    wr(3'd4, 8'hFF, 1, "wr_a4");
    rd(3'd4, 8'h00, 1, "rd_a4");
`endif
    rd(3'd0, 8'h10, 0, "cr1_intact");
    rd(3'd1, 8'h00, 0, "cr2_intact");
    rd(3'd2, 8'h00, 0, "br_intact");

    // Simultaneous push and pop on a full RX FIFO
    for (int i = 0; i < 4; i++) rx_pulse(8'hA1 + 8'(i));
    apb(1'b0, 3'd5, 8'h00, 1'b1, 8'hB5, r, e);
    check("pp_prdata", r, 8'hA1);
    check("pp_pslverr", e, 0);
    rd(3'd3, 8'hB8, 0, "sr_pp_full");
    rd(3'd5, 8'hA2, 0, "pp_rd2");
    rd(3'd5, 8'hA3, 0, "pp_rd3");
    rd(3'd5, 8'hA4, 0, "pp_rd4");
    rd(3'd5, 8'hB5, 0, "pp_rd5");
    rd(3'd3, 8'h30, 0, "sr_pp_empty");

    // Reset asserted in the middle of ENABLE
    wr(3'd2, 8'h55, 0, "br_set");
    rx_pulse(8'h5A);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 3'd5;
    @(posedge PCLK); #1;
    PENABLE = 1;
    n = 0;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && n < 8) begin
      @(negedge PCLK);
      n++;
    end
    check("mid_pready", PREADY, 1);
    check("mid_prdata", PRDATA, 8'h5A);
    PRESETn = 0;
    #1;
    check("mid_rst_pready", PREADY, 0);
    check("mid_rst_prdata", PRDATA, 0);
    check("mid_rst_pslverr", PSLVERR, 0);
    check("mid_rst_mode", spi_mode, 2'b10);
    check("mid_rst_mosi", mosi_data, 0);
    check("mid_rst_send", send_data, 0);
    check("mid_rst_irq", spi_interrupt_request, 0);
    check("mid_rst_sppr", sppr, 0);
    PSEL = 0; PENABLE = 0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK) PRESETn = 1;
    rd(3'd0, 8'h04, 0, "post_rst_cr1");
    rd(3'd3, 8'h30, 0, "post_rst_sr");

    // Randomized traffic against the queue model, starting from reset state
    m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_thr = 8'h01; m_ovr = 0;
    txq.delete(); rxq.delete();
    exp_pulses = 0; have_last = 0; last_mosi = 8'h00;
    base = pulses;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        v = 8'($urandom);
        rx_pulse(v);
        if (rxq.size() < 4) rxq.push_back(v);
        else m_ovr = 1;
      end else begin
        a = ($urandom_range(0, 2) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
        d = 8'($urandom);
        w = (op == 1);
        exp_err = !m_mapped(a) || (w && a == 3'd5 && txq.size() == 4);
        apb(w, a, d, 1'b0, 8'h00, r, e);
        check("rand_pslverr", e, exp_err);
        if (!w) check("rand_prdata", r, exp_err ? 8'h00 : m_read(a));
        if (w && !exp_err) begin
          case (a)
            3'd0: m_cr1 = d;
            3'd1: m_cr2 = d;
            3'd2: m_br = d & 8'h77;
            3'd3: if (d[0]) m_ovr = 0;
            3'd4: m_thr = {5'd0, d[2:0]};
            3'd5: txq.push_back(d);
            default: ;
          endcase
        end
        if (!w && a == 3'd5 && rxq.size() != 0) void'(rxq.pop_front());
      end
      settle(12);
      if (m_cr1[6] && m_cr1[4] && txq.size() != 0) begin
        exp_pulses += txq.size();
        last_mosi = txq[txq.size() - 1];
        have_last = 1;
        txq.delete();
      end
      check("rand_pulses", pulses - base, exp_pulses);
      if (have_last) check("rand_mosi", mosi_data, last_mosi);
      check("rand_mode", spi_mode, !m_cr1[6] ? 2'b10 : (m_cr2[1] ? 2'b01 : 2'b00));
      check("rand_irq", spi_interrupt_request, m_irq());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
